// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full-adder slice iterated LSB-first,
// producing the same sum/carry as a WIDTH-bit ripple-carry adder.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   valid_i, ready_o    request handshake (ready_o high only in IDLE)
//   a_i, b_i            operands, sampled on request handshake
//   sub_i               0 = add, 1 = subtract
//   carry_i             carry-in (add) / borrow-in (subtract)
//   valid_o, ready_i    response handshake (valid_o high only in DONE)
//   sum_o, carry_o      registered result and carry/borrow-out
module serial_addsub #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    input  logic             carry_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             c_q;
    logic             sub_q;
    logic [CW-1:0]    cnt;
    // Holds the low WIDTH-1 result bits while iterating; the final bit
    // goes straight into sum_q so partial results never reach sum_o.
    logic [WIDTH-2:0] res_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;

    logic accept;
    logic step;
    logic last;
    logic s;
    logic c_nx;

    assign accept = valid_i && (state == IDLE);
    assign step   = (state == RUN);
    assign last   = step && (cnt == LAST);

    assign s    = a_q[0] ^ b_q[0] ^ c_q;
    assign c_nx = (a_q[0] & b_q[0]) | (a_q[0] & c_q) | (b_q[0] & c_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (valid_i) state_nx = RUN;
            RUN:  if (cnt == LAST) state_nx = DONE;
            DONE: if (ready_i) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= 1'b0;
            sub_q   <= 1'b0;
            cnt     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else if (accept) begin
            // Subtraction is a + ~b + ~borrow_in; the borrow-out is the
            // inverted final carry.
            a_q   <= a_i;
            b_q   <= sub_i ? ~b_i : b_i;
            c_q   <= carry_i ^ sub_i;
            sub_q <= sub_i;
            cnt   <= '0;
        end else if (step) begin
            a_q   <= a_q >> 1;
            b_q   <= b_q >> 1;
            c_q   <= c_nx;
            res_q <= (WIDTH-1)'({s, res_q} >> 1);
            if (last) begin
                sum_q   <= {s, res_q};
                carry_q <= c_nx ^ sub_q;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign ready_o = (state == IDLE);
    assign valid_o = (state == DONE);
    assign sum_o   = sum_q;
    assign carry_o = carry_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed and random checks of serial_addsub at WIDTH=4 and WIDTH=8.
module tb_serial_addsub;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic       v4_in = 0, r4_out, v4_out, r4_in = 0;
    logic [3:0] a4 = 0, b4 = 0, s4;
    logic       sub4 = 0, ci4 = 0, co4;

    logic       v8_in = 0, r8_out, v8_out, r8_in = 0;
    logic [7:0] a8 = 0, b8 = 0, s8;
    logic       sub8 = 0, ci8 = 0, co8;

    serial_addsub #(.WIDTH(4)) u4 (
        .clk_i(clk), .rst_i(rst),
        .valid_i(v4_in), .ready_o(r4_out),
        .a_i(a4), .b_i(b4), .sub_i(sub4), .carry_i(ci4),
        .valid_o(v4_out), .ready_i(r4_in),
        .sum_o(s4), .carry_o(co4)
    );

    serial_addsub #(.WIDTH(8)) u8 (
        .clk_i(clk), .rst_i(rst),
        .valid_i(v8_in), .ready_o(r8_out),
        .a_i(a8), .b_i(b8), .sub_i(sub8), .carry_i(ci8),
        .valid_o(v8_out), .ready_i(r8_in),
        .sum_o(s8), .carry_o(co8)
    );

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic.
    task automatic model(input int w, input int a, input int b,
                         input logic sub, input logic ci,
                         output int es, output logic ec);
        int t;
        int m;
        m = 1 << w;
        if (!sub) begin
            t  = a + b + int'(ci);
            ec = (t >= m);
            es = t % m;
        end else begin
            t  = a - b - int'(ci);
            ec = (t < 0);
            es = (t + m) % m;
        end
    endtask

    task automatic run_op4(string tag, logic [3:0] a, logic [3:0] b,
                           logic sub, logic ci, logic [3:0] es,
                           logic ec, bit hs);
        int n;
        n = 0;
        while (!r4_out && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, 32'(r4_out), 32'd1);
        a4 = a; b4 = b; sub4 = sub; ci4 = ci; v4_in = 1;
        tick();
        v4_in = 0; a4 = ~a; b4 = ~b; sub4 = ~sub; ci4 = ~ci;
        check({tag, "_busy"}, 32'(r4_out), 32'd0);
        n = 0;
        while (!v4_out && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_lat"}, n, 4);
        check({tag, "_sum"}, 32'(s4), 32'(es));
        check({tag, "_co"}, 32'(co4), 32'(ec));
        if (hs) begin
            r4_in = 1;
            tick();
            r4_in = 0;
            check({tag, "_rdy"}, {r4_out, v4_out}, 32'b10);
            check({tag, "_keep"}, {co4, s4}, {ec, es});
        end
    endtask

    task automatic rand4(int nv);
        int n, prev, es;
        logic ec;
        logic [3:0] a, b;
        logic sub, ci;
        prev = -1;
        r4_in = 1;
        for (int i = 0; i < nv; i++) begin
            a = 4'($urandom); b = 4'($urandom);
            sub = 1'($urandom); ci = 1'($urandom);
            a4 = a; b4 = b; sub4 = sub; ci4 = ci; v4_in = 1;
            n = 0;
            while (!r4_out && n < 20) begin
                tick();
                n++;
            end
            tick();
            if (prev >= 0) check("r4_gap", cyc - prev, 6);
            prev = cyc;
            a4 = ~a; b4 = ~b;
            n = 0;
            while (!v4_out && n < 20) begin
                tick();
                n++;
            end
            model(4, int'(a), int'(b), sub, ci, es, ec);
            check("r4_sum", 32'(s4), 32'(es));
            check("r4_co", 32'(co4), 32'(ec));
        end
        v4_in = 0;
        tick();
        r4_in = 0;
    endtask

    task automatic rand8(int nv);
        int n, prev, es;
        logic ec;
        logic [7:0] a, b;
        logic sub, ci;
        prev = -1;
        r8_in = 1;
        for (int i = 0; i < nv; i++) begin
            a = 8'($urandom); b = 8'($urandom);
            sub = 1'($urandom); ci = 1'($urandom);
            a8 = a; b8 = b; sub8 = sub; ci8 = ci; v8_in = 1;
            n = 0;
            while (!r8_out && n < 30) begin
                tick();
                n++;
            end
            tick();
            if (prev >= 0) check("r8_gap", cyc - prev, 10);
            prev = cyc;
            a8 = ~a; b8 = ~b;
            n = 0;
            while (!v8_out && n < 30) begin
                tick();
                n++;
            end
            model(8, int'(a), int'(b), sub, ci, es, ec);
            check("r8_sum", 32'(s8), 32'(es));
            check("r8_co", 32'(co8), 32'(ec));
        end
        v8_in = 0;
        tick();
        r8_in = 0;
    endtask

    initial begin
        int n;
        logic [4:0] held;

        rst = 1;
        repeat (2) tick();
        check("rst4", {r4_out, v4_out, co4, s4}, 32'b1000000);
        check("rst8", {r8_out, v8_out, co8, s8}, 32'b10_0_00000000);
        rst = 0;

        run_op4("add0", 4'b0000, 4'b1001, 0, 0, 4'b1001, 0, 1);
        run_op4("add1", 4'b1000, 4'b1001, 0, 1, 4'b0010, 1, 1);
        run_op4("add2", 4'b1111, 4'b0000, 0, 1, 4'b0000, 1, 1);
        run_op4("sub0", 4'b0100, 4'b1101, 1, 0, 4'b0111, 1, 1);
        run_op4("sub1", 4'b1001, 4'b0010, 1, 1, 4'b0110, 0, 1);
        run_op4("sub2", 4'b0011, 4'b0011, 1, 0, 4'b0000, 0, 1);

        // Backpressure with junk on the request side.
        run_op4("bp", 4'b1000, 4'b1001, 0, 1, 4'b0010, 1, 0);
        held = {co4, s4};
        for (int i = 0; i < 3; i++) begin
            v4_in = 1;
            a4 = 4'($urandom); b4 = 4'($urandom);
            sub4 = 1'($urandom); ci4 = 1'($urandom);
            tick();
            check("bp_hold", {v4_out, r4_out}, 32'b10);
            check("bp_res", {co4, s4}, 32'b10010);
        end
        v4_in = 0;
        r4_in = 1;
        tick();
        r4_in = 0;
        check("bp_rel", {r4_out, v4_out}, 32'b10);
        tick();
        check("bp_noacc", {r4_out, co4, s4}, {1'b1, held});

        // Reset after two bit cycles.
        a4 = 4'b0101; b4 = 4'b0011; sub4 = 0; ci4 = 0; v4_in = 1;
        tick();
        v4_in = 0;
        repeat (2) tick();
        rst = 1;
        tick();
        rst = 0;
        check("mid_rst", {r4_out, v4_out, co4, s4}, 32'b1000000);
        n = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (v4_out) n++;
        end
        check("no_pulse", n, 0);
        run_op4("post", 4'b0110, 4'b0111, 0, 0, 4'b1101, 0, 1);

        rand4(1000);
        rand8(1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_addsub.md
# serial_addsub

Bit-serial adder/subtractor computing the same WIDTH-bit sum/carry function as the combinational ripple-carry adder, one bit per clock, with valid/ready handshakes on both sides. It accepts operands, a mode bit and a carry/borrow-in on a request handshake. It then iterates LSB-first through a single full-adder slice and presents a registered result on a response handshake. It serves area-constrained datapaths and acts as a cycle-accurate companion model when verifying the combinational adder.

## Interface
- WIDTH, 4, operand/result width in bits; legal range WIDTH >= 2.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous and active-high.
- valid_i  input  1  request valid.
- ready_o  output  1  request ready; high only in IDLE.
- a_i  input  WIDTH  operand A; sampled on request handshake.
- b_i  input  WIDTH  operand B; sampled on request handshake.
- sub_i  input  1  mode: 0 = add, 1 = subtract; sampled on request handshake.
- carry_i  input  1  carry-in for add, borrow-in for subtract; sampled on request handshake.
- valid_o  output  1  result valid; high only in DONE.
- ready_i  input  1  result accepted by consumer.
- sum_o  output  WIDTH  result, registered.
- carry_o  output  1  carry-out for add, borrow-out for subtract; registered.

## Operation
- FSM states are IDLE, RUN and DONE.
- IDLE: ready_o=1. On valid_i && ready_o, capture the following, then go to RUN:
  - A into an operand shift register.
  - Effective B (b_i when add, ~b_i when subtract) into a second shift register.
  - Internal carry c = carry_i when add, ~carry_i when subtract.
  - Bit counter cleared to 0.
  - Mode stored.
- RUN: each cycle computes s = a0 ^ b0 ^ c and c' = majority(a0, b0, c).
  - s shifts into the result register MSB-first, so the LSB lands at bit 0 after WIDTH shifts.
  - Operand registers shift right; the counter increments.
  - When the counter reaches WIDTH-1, the final bit is processed and the state moves to DONE.
- Final carry register: carry_o = c_final when add, ~c_final (borrow-out) when subtract.
- Arithmetic:
  - Add: {carry_o, sum_o} = a + b + carry_i.
  - Subtract: sum_o = (a - b - carry_i) mod 2^WIDTH; carry_o = 1 iff a < b + carry_i (unsigned).
- DONE: valid_o=1; sum_o and carry_o are stable. On ready_i, go to IDLE. Otherwise stay, holding all outputs.
- sum_o/carry_o keep the last result after handshake until the next op completes. Partial results are never visible on sum_o.
- valid_i and operand changes while in RUN/DONE are ignored (ready_o=0).
- Counter width is $clog2(WIDTH); no wrap beyond WIDTH-1.

## Timing
- Reset values: state=IDLE, ready_o=1, valid_o=0, sum_o=0, carry_o=0, counter=0, internal registers=0.
- rst_i asserted in any state, including mid-RUN or in DONE with valid_o=1: the next edge forces reset values. Any in-flight op is discarded with no valid_o pulse.
- Latency: request handshake at edge k means valid_o rises after edge k+WIDTH.
- Response: a handshake at edge m gives ready_o=1 after edge m.
- Throughput: one op per WIDTH+2 cycles with ready_i held high.
- valid_o/ready_o, sum_o and carry_o are register-driven; there is no combinational path from valid_i or ready_i to any output.
- ready_i high while not in DONE has no effect.

## Test plan
- Reset, then add with a=0000, b=1001, carry_i=0 -> valid_o exactly 4 cycles after accept; sum_o=1001, carry_o=0.
- Add with a=1000, b=1001, carry_i=1 -> sum_o=0010, carry_o=1; follow with a=1111, b=0000, carry_i=1 -> sum_o=0000, carry_o=1 (full carry ripple).
- Subtract:
  - a=0100, b=1101, carry_i=0 -> sum_o=0111, carry_o=1 (borrow).
  - a=1001, b=0010, carry_i=1 -> sum_o=0110, carry_o=0.
  - a=0011, b=0011, carry_i=0 -> sum_o=0000, carry_o=0.
- Backpressure: hold ready_i=0 for 3 cycles in DONE -> valid_o, sum_o and carry_o stable and ready_o=0 throughout. Toggle valid_i and operands meanwhile -> result unchanged and no new op accepted.
- Reset mid-RUN (after 2 bit cycles) -> next cycle ready_o=1, valid_o=0, sum_o=0, carry_o=0, and no valid_o pulse follows. A new op then completes correctly.
- Random back-to-back ops, valid_i and ready_i held high, 1000 vectors, WIDTH=4 and WIDTH=8 -> every result matches a reference model, and successive accepts are WIDTH+2 cycles apart.
